// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, issue-unit state encoding and FIFO payload type.
package mips_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned ADDR_W    = 32;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DROP = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } issue_entry_t;

    function automatic logic [OP_W-1:0] op_field(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [FUNCT_W-1:0] funct_field(input logic [INSTR_W-1:0] instr);
        return instr[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/instr_issue_unit_if.sv
// Fetch-memory and decode-issue signals of the instruction issue unit.
interface instr_issue_unit_if;
    import mips_pkg::*;

    logic                 imem_req_o;
    logic [ADDR_W-1:0]    imem_addr_o;
    logic [INSTR_W-1:0]   imem_data_i;
    logic                 redirect_i;
    logic [ADDR_W-1:0]    redirect_pc_i;
    logic                 issue_valid_o;
    logic                 issue_ready_i;
    logic [INSTR_W-1:0]   instr_o;
    logic [ADDR_W-1:0]    pc_o;
    logic [OP_W-1:0]      op_field_o;
    logic [FUNCT_W-1:0]   function_field_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_data_i, redirect_i, redirect_pc_i,
        output issue_valid_o,
        input  issue_ready_i,
        output instr_o, pc_o, op_field_o, function_field_o
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_data_i, redirect_i, redirect_pc_i,
        input  issue_valid_o,
        output issue_ready_i,
        input  instr_o, pc_o, op_field_o, function_field_o
    );

endinterface

// File: rtl/issue_fifo.sv
// Synchronous {pc, instr} FIFO with push/pop/flush; DEPTH must be a power of two.
module issue_fifo
    import mips_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  issue_entry_t     din,
    output issue_entry_t     head,
    output logic [CNT_W-1:0] count
);

    issue_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_issue_unit.sv
// Fetches MIPS words from a 1-cycle synchronous imem, buffers and issues them to decode.
// Optional stall counter output enabled by defining ISSUE_PERF_CNT_EN.
module instr_issue_unit
    import mips_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] PC_RESET   = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    instr_issue_unit_if.master bus
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    issue_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              inflight_q;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    issue_entry_t      head;
    issue_entry_t      tail_entry;
    logic              req_c;
    logic              redirect_c;
    logic              push_c;
    logic              pop_c;
    logic              valid_c;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^bus.redirect_pc_i[1:0];

    // The outstanding response is counted against FIFO capacity.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight_q);
    assign valid_c   = (count != '0);

    always_comb begin
        redirect_c = 1'b0;
        req_c      = 1'b0;
        push_c     = 1'b0;
        pop_c      = valid_c && bus.issue_ready_i;
        if (state_q != IDLE) begin
            redirect_c = bus.redirect_i;
        end
        if (state_q == RUN) begin
            req_c = (occupancy < (CNT_W + 1)'(FIFO_DEPTH)) && !bus.redirect_i;
        end
        if (state_q != DROP) begin
            push_c = inflight_q;
        end
    end

    assign tail_entry = '{pc: pc_q - 32'd4, instr: bus.imem_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= PC_RESET;
            inflight_q <= 1'b0;
        end else begin
            // Memory answers exactly one cycle after a request.
            inflight_q <= req_c;
            case (state_q)
                IDLE:    state_q <= RUN;
                RUN,
                DROP:    state_q <= (redirect_c && inflight_q) ? DROP : RUN;
                default: state_q <= IDLE;
            endcase
            if (redirect_c) begin
                pc_q <= {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
            end else if (req_c) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_c),
        .pop   (pop_c),
        .flush (redirect_c),
        .din   (tail_entry),
        .head  (head),
        .count (count)
    );

    assign bus.imem_req_o       = req_c;
    assign bus.imem_addr_o      = pc_q;
    assign bus.issue_valid_o    = valid_c;
    assign bus.instr_o          = head.instr;
    assign bus.pc_o             = head.pc;
    assign bus.op_field_o       = op_field(head.instr);
    assign bus.function_field_o = funct_field(head.instr);

`ifdef ISSUE_PERF_CNT_EN
    // Saturating count of cycles where decode back-pressures a valid head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (valid_c && !bus.issue_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit with a 1-cycle imem model (word = addr + 0x1000).
module tb_instr_issue_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    instr_issue_unit_if bus();

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    instr_issue_unit #(.FIFO_DEPTH(2), .PC_RESET(32'h0000_0000)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0100: return 32'h3C01_0005;
            32'h0000_0104: return 32'h0000_0007;
            default:       return addr + 32'h0000_1000;
        endcase
    endfunction

    always @(posedge clk) begin
        bus.imem_data_i <= bus.imem_req_o ? mem_word(bus.imem_addr_o) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, "_req"}, 32'(bus.imem_req_o), 32'(req));
        if (req) check({tag, "_addr"}, bus.imem_addr_o, addr);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_valid"}, 32'(bus.issue_valid_o), 32'd1);
        check({tag, "_pc"}, bus.pc_o, pc);
        check({tag, "_instr"}, bus.instr_o, instr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.issue_ready_i = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        repeat (3) @(negedge clk);

        // IDLE cycle straight after reset
        check("rst_req", 32'(bus.imem_req_o), 32'd0);
        check("rst_valid", 32'(bus.issue_valid_o), 32'd0);
        check("rst_instr", bus.instr_o, 32'h0);
        check("rst_pc", bus.pc_o, 32'h0);
        rst = 1'b0;

        // ready=1 streaming
        @(negedge clk); check_req("s1", 1'b1, 32'h0);
        check("s1_valid", 32'(bus.issue_valid_o), 32'd0);
        @(negedge clk); check_req("s2", 1'b1, 32'h4);
        @(negedge clk); check_head("s3", 32'h0, 32'h0000_1000); check_req("s3", 1'b0, 32'h0);
        @(negedge clk); check_head("s4", 32'h4, 32'h0000_1004); check_req("s4", 1'b1, 32'h8);
        @(negedge clk); check("s5_valid", 32'(bus.issue_valid_o), 32'd0); check_req("s5", 1'b1, 32'hC);

        // ready=0: fill to capacity, then drain in order
        rst = 1'b1; bus.issue_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); check_req("f1", 1'b1, 32'h0);
        @(negedge clk); check_req("f2", 1'b1, 32'h4);
        @(negedge clk); check_head("f3", 32'h0, 32'h0000_1000); check_req("f3", 1'b0, 32'h0);
        @(negedge clk); check_head("f4", 32'h0, 32'h0000_1000); check_req("f4", 1'b0, 32'h0);
        @(negedge clk); check_head("f5", 32'h0, 32'h0000_1000); check_req("f5", 1'b0, 32'h0);
        bus.issue_ready_i = 1'b1;
        @(negedge clk); check_head("f6", 32'h4, 32'h0000_1004); check_req("f6", 1'b1, 32'h8);
        @(negedge clk); check("f7_valid", 32'(bus.issue_valid_o), 32'd0); check_req("f7", 1'b1, 32'hC);

        // redirect with a fetch in flight: DROP, then refetch at 0x40
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0043;
        #1 check_req("r0", 1'b0, 32'h0);
        @(negedge clk); bus.redirect_i = 1'b0;
        #1 check_req("r1_drop", 1'b0, 32'h0); check("r1_valid", 32'(bus.issue_valid_o), 32'd0);
        @(negedge clk); check_req("r2", 1'b1, 32'h40); check("r2_valid", 32'(bus.issue_valid_o), 32'd0);
        @(negedge clk); check_req("r3", 1'b1, 32'h44); check("r3_valid", 32'(bus.issue_valid_o), 32'd0);
        @(negedge clk); check_head("r4", 32'h40, 32'h0000_1040);

        // redirect with nothing in flight: decode fields of lui / funct=7
        bus.issue_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0102;
        #1 check_req("d0", 1'b0, 32'h0);
        @(negedge clk); bus.redirect_i = 1'b0;
        #1 check_req("d1", 1'b1, 32'h100); check("d1_valid", 32'(bus.issue_valid_o), 32'd0);
        @(negedge clk); check_req("d2", 1'b1, 32'h104);
        @(negedge clk); check_head("d3", 32'h100, 32'h3C01_0005);
        check("d3_op", 32'(bus.op_field_o), 32'h0F);
        check("d3_funct", 32'(bus.function_field_o), 32'h05);
        @(negedge clk); check_head("d4", 32'h100, 32'h3C01_0005); check_req("d4", 1'b0, 32'h0);
        bus.issue_ready_i = 1'b1;
        @(negedge clk); check_head("d5", 32'h104, 32'h0000_0007);
        check("d5_op", 32'(bus.op_field_o), 32'h00);
        check("d5_funct", 32'(bus.function_field_o), 32'h07);
        bus.issue_ready_i = 1'b0;

        // fetch PC wraps from 0xFFFFFFFC to 0
        repeat (2) @(negedge clk);
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFF;
        @(negedge clk); bus.redirect_i = 1'b0;
        #1 check_req("w1", 1'b1, 32'hFFFF_FFFC);
        @(negedge clk); check_req("w2", 1'b1, 32'h0);
        @(negedge clk); check_head("w3", 32'hFFFF_FFFC, 32'h0000_0FFC);

        // reset mid-operation discards the FIFO and the pending response
        rst = 1'b1;
        @(negedge clk); check("mr_valid", 32'(bus.issue_valid_o), 32'd0); check_req("mr", 1'b0, 32'h0);
        rst = 1'b0;
        @(negedge clk); check_req("mr1", 1'b1, 32'h0); check("mr1_valid", 32'(bus.issue_valid_o), 32'd0);

`ifdef ISSUE_PERF_CNT_EN
        rst = 1'b1;
        @(negedge clk); check("pc_rst", stall_cnt, 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("pc_valid", 32'(bus.issue_valid_o), 32'd1);
        check("pc_cnt5", stall_cnt, 32'd5);
        rst = 1'b1;
        @(negedge clk); check("pc_clr", stall_cnt, 32'd0);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
